event_collector: RTL and testbench
==================================

# event_collector

Parametrised event-capture and readout block behind `processing_system`, and the hardware successor to the bench's per-cycle event logger. It watches the `NUM_UNITS` per-channel classifier event lanes and records each new non-zero event, tagged with a sample-count timestamp and its channel index. Records are merged round-robin into one FIFO and read out over a valid/ready interface. Lost events are counted, not silently discarded.

## Interface
- `NUM_UNITS`, 4: number of channels (1–64).
- `EVT_W`, 2: event code width per channel; code 0 means "no event".
- `TS_W`, 16: timestamp width.
- `FIFO_DEPTH`, 16: record FIFO depth; must be a power of 2, ≥2.
- `CH_W` (localparam): max(1, clog2(`NUM_UNITS`)).
- `REC_W` (localparam): `TS_W`+`CH_W`+`EVT_W`.

- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `en`  in  1  capture enable.
- `sample_strobe`  in  1  one-cycle pulse per input sample; advances the timestamp.
- `event_in_array`  in  `EVT_W*NUM_UNITS`  channel k occupies `[EVT_W*k +: EVT_W]`.
- `rd_valid`  out  1  FIFO non-empty.
- `rd_ready`  in  1  consumer accepts the head record.
- `rd_data`  out  `REC_W`  head record, packed as {ts, ch, evt}.
- `fifo_count`  out  clog2(`FIFO_DEPTH`)+1  current occupancy.
- `overflow_count`  out  16  number of dropped events, saturating.
- `clr_overflow`  in  1  synchronous clear of `overflow_count`.
- `ts_now`  out  `TS_W`  current timestamp.

## Operation
- **Timestamp.** `ts_now` increments by 1 on each cycle where `en && sample_strobe`. It wraps from 2^`TS_W`−1 to 0.
- **Edge detect.** `prev[k]` registers lane k every cycle, regardless of `en`. A new event on lane k is `en && lane[k]!=0 && lane[k]!=prev[k]`. A held non-zero level produces one record only. A direct change between two non-zero codes (e.g. 1→2) counts as a new event.
- **Pending slots.** Each channel has one slot {valid, evt, ts}. On a new event:
  - If the slot is empty, load it with the current `ts_now` value, sampled before any increment in the same cycle.
  - If the slot is full, the slot is unchanged, the new event is dropped, and `overflow_count` increments.
- **Arbiter.** A round-robin pointer names the last granted channel. Each cycle, when `fifo_count < FIFO_DEPTH`, the first valid slot searching from pointer+1 upward (with wrap) is written to the FIFO. That slot clears and the pointer moves to it. At most one grant per cycle.
  - A FIFO pop in the same cycle does not create room for a push; a full FIFO blocks pushes for that cycle.
  - A slot that clears and is reloaded by a new event in the same cycle keeps the new event; no drop is counted.
- **FIFO.** First-word-fall-through. `rd_data` presents the head whenever `rd_valid`=1. A pop happens on `rd_valid && rd_ready`. `rd_data` is don't-care while empty.
- **Disable.** `en`=0 stops new captures and stops the timestamp. Pending slots still drain and the FIFO can still be read.
- **Overflow counter.** Saturates at 0xFFFF. When `clr_overflow` and an increment occur in the same cycle, the clear wins and the result is 0.
- **Reset.** All state is cleared:
  - FIFO empty, every slot invalid, `prev`=0.
  - Pointer = `NUM_UNITS`−1, so channel 0 has first priority.
  - Outputs: `rd_valid`=0, `fifo_count`=0, `overflow_count`=0, `ts_now`=0, `rd_data`=0.

## Timing
- Event latency: lane change sampled at edge N → slot valid after N → FIFO write at edge N+1 → `rd_valid`=1 in cycle N+2 when uncontended.
- Contention: with j channels ahead of channel k in round-robin order, channel k's record is written j cycles later.
- Pop: `fifo_count` decrements on the same edge as the accepting `rd_ready` cycle. The next record appears on `rd_data` combinationally after that edge.
- Simultaneous push and pop: `fifo_count` is unchanged.
- `ts_now` updates on the edge after the strobe cycle.
- Reset assertion takes effect immediately and asynchronously, mid-transfer included. Records already in the FIFO are lost. Deassertion is synchronised externally.

## Test plan
- Single event: `sample_strobe` pulsed 5 times, then lane 2 set 0→1 and held 10 cycles → exactly one record {ts=5, ch=2, evt=1}. `rd_valid` rises 2 cycles after the lane change.
- Simultaneous events: all 4 lanes 0→2 in one cycle, `rd_ready`=1 → records appear in ch order 0,1,2,3 on consecutive cycles with equal ts. Next burst after ch 3 is granted starts at ch 0.
- Backpressure: `rd_ready`=0, 20 distinct events spread across channels at ≤1 per channel per drain → `fifo_count` stops at 16, ≤4 pending slots held, `overflow_count`=0. Then `rd_ready`=1 → all 20 records drain in order, nothing lost.
- Drop path: FIFO full, lane 1 toggles 1→0→2→0→1 → first event held in slot, next 2 dropped, `overflow_count`=2. `clr_overflow` → 0.
- Wrap and code change: `TS_W`=4, 17 strobes → `ts_now`=1. Lane 0 changes 1→3 directly → new record with evt=3.
- Reset mid-operation: FIFO at 7 entries, 3 slots pending, `rst_n` pulsed low → all outputs at reset values immediately. First post-reset event is granted channel 0 first, with ts=0.

Source files
------------

// File: rtl/event_collector.sv
// Per-channel event capture with timestamped pending slots,
// round-robin merge into a first-word-fall-through record FIFO.
module event_collector #(
   parameter  int NUM_UNITS  = 4,
   parameter  int EVT_W      = 2,
   parameter  int TS_W       = 16,
   parameter  int FIFO_DEPTH = 16,
   localparam int CH_W       = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1,
   localparam int REC_W      = TS_W + CH_W + EVT_W,
   localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       en,
   input  logic                       sample_strobe,
   input  logic [EVT_W*NUM_UNITS-1:0] event_in_array,
   output logic                       rd_valid,
   input  logic                       rd_ready,
   output logic [REC_W-1:0]           rd_data,
   output logic [CNT_W-1:0]           fifo_count,
   output logic [15:0]                overflow_count,
   input  logic                       clr_overflow,
   output logic [TS_W-1:0]            ts_now
);

   localparam int AW = $clog2(FIFO_DEPTH);

   logic [EVT_W-1:0] lane     [NUM_UNITS];
   logic [EVT_W-1:0] prev     [NUM_UNITS];
   logic [EVT_W-1:0] slot_evt [NUM_UNITS];
   logic [TS_W-1:0]  slot_ts  [NUM_UNITS];
   logic [NUM_UNITS-1:0] slot_v;
   logic [NUM_UNITS-1:0] new_ev;
   logic [NUM_UNITS-1:0] drop;
   logic [NUM_UNITS-1:0] clr;

   logic [CH_W-1:0]  ptr;
   logic [CH_W-1:0]  gnt_ch;
   logic             gnt_v;
   logic             push;
   logic             pop;
   logic [6:0]       ndrop;
   logic [16:0]      ovf_sum;

   logic [REC_W-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0]    wp;
   logic [AW-1:0]    rp;
   logic [CNT_W-1:0] cnt;

   always_comb begin
      for (int k = 0; k < NUM_UNITS; k++) begin
         lane[k] = event_in_array[EVT_W*k +: EVT_W];
      end
   end

   // Search starts one past the last grant so every channel gets a turn.
   always_comb begin
      int j;
      j      = 0;
      gnt_v  = 1'b0;
      gnt_ch = '0;
      for (int i = 1; i <= NUM_UNITS; i++) begin
         j = int'(ptr) + i;
         if (j >= NUM_UNITS) j = j - NUM_UNITS;
         if (!gnt_v && slot_v[j]) begin
            gnt_v  = 1'b1;
            gnt_ch = CH_W'(j);
         end
      end
   end

   assign push = gnt_v && (cnt < CNT_W'(FIFO_DEPTH));
   assign pop  = rd_valid && rd_ready;

   always_comb begin
      ndrop = '0;
      for (int k = 0; k < NUM_UNITS; k++) begin
         new_ev[k] = en && (lane[k] != '0) && (lane[k] != prev[k]);
         clr[k]    = push && (gnt_ch == CH_W'(k));
         drop[k]   = new_ev[k] && slot_v[k] && !clr[k];
         ndrop     = ndrop + 7'(drop[k]);
      end
   end

   assign ovf_sum = {1'b0, overflow_count} + 17'(ndrop);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ts_now         <= '0;
         overflow_count <= '0;
         ptr            <= CH_W'(NUM_UNITS - 1);
         slot_v         <= '0;
         for (int k = 0; k < NUM_UNITS; k++) begin
            prev[k]     <= '0;
            slot_evt[k] <= '0;
            slot_ts[k]  <= '0;
         end
      end else begin
         if (en && sample_strobe) ts_now <= ts_now + 1'b1;
         if (clr_overflow)        overflow_count <= '0;
         else if (ovf_sum[16])    overflow_count <= 16'hFFFF;
         else                     overflow_count <= ovf_sum[15:0];
         if (push) ptr <= gnt_ch;
         for (int k = 0; k < NUM_UNITS; k++) begin
            prev[k] <= lane[k];
            if (new_ev[k] && (clr[k] || !slot_v[k])) begin
               slot_v[k]   <= 1'b1;
               slot_evt[k] <= lane[k];
               slot_ts[k]  <= ts_now;
            end else if (clr[k]) begin
               slot_v[k]   <= 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wp] <= {slot_ts[gnt_ch], gnt_ch, slot_evt[gnt_ch]};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wp  <= '0;
         rp  <= '0;
         cnt <= '0;
      end else begin
         if (push) wp <= wp + 1'b1;
         if (pop)  rp <= rp + 1'b1;
         unique case ({push, pop})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
      end
   end

   assign rd_valid   = (cnt != '0);
   assign rd_data    = rd_valid ? mem[rp] : '0;
   assign fifo_count = cnt;

endmodule

// File: tb/tb_event_collector.sv
// Directed bench for event_collector: default instance plus a
// narrow-timestamp instance for wrap checks.
module tb_event_collector;

   logic        clk = 1'b0;
   logic        rst_n, en, strobe, rd_ready, clr;
   logic [7:0]  ev;
   logic        rd_valid;
   logic [19:0] rd_data;
   logic [4:0]  fcnt;
   logic [15:0] ovf;
   logic [15:0] ts;

   logic [7:0]  ev_w;
   logic        rdy_w, vld_w;
   logic [7:0]  dat_w;
   logic [4:0]  cnt_w;
   logic [15:0] ovf_w;
   logic [3:0]  ts_w;

   int nvec = 0;
   int nerr = 0;
   int exp_ts = 0;

   always #5 clk = ~clk;

   event_collector u_dut (
      .clk(clk), .rst_n(rst_n), .en(en), .sample_strobe(strobe),
      .event_in_array(ev), .rd_valid(rd_valid), .rd_ready(rd_ready),
      .rd_data(rd_data), .fifo_count(fcnt), .overflow_count(ovf),
      .clr_overflow(clr), .ts_now(ts)
   );

   event_collector #(.TS_W(4)) u_wrap (
      .clk(clk), .rst_n(rst_n), .en(en), .sample_strobe(strobe),
      .event_in_array(ev_w), .rd_valid(vld_w), .rd_ready(rdy_w),
      .rd_data(dat_w), .fifo_count(cnt_w), .overflow_count(ovf_w),
      .clr_overflow(clr), .ts_now(ts_w)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse(input int n);
      repeat (n) begin
         strobe = 1'b1;
         tick();
         strobe = 1'b0;
         exp_ts++;
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0; ev = '0; ev_w = '0; rd_ready = 1'b0;
      rdy_w = 1'b0; strobe = 1'b0; clr = 1'b0; en = 1'b1;
      tick();
      tick();
      rst_n = 1'b1;
      exp_ts = 0;
   endtask

   task automatic test_reset();
      do_reset();
      nvec++;
      if (rd_valid !== 1'b0) begin
         nerr++; $display("FAIL reset_valid: got %b want 0", rd_valid);
      end
      nvec++;
      if (fcnt !== 5'd0) begin
         nerr++; $display("FAIL reset_count: got %0d want 0", fcnt);
      end
      nvec++;
      if (ovf !== 16'd0) begin
         nerr++; $display("FAIL reset_ovf: got %0d want 0", ovf);
      end
      nvec++;
      if (ts !== 16'd0) begin
         nerr++; $display("FAIL reset_ts: got %0d want 0", ts);
      end
      nvec++;
      if (rd_data !== 20'd0) begin
         nerr++; $display("FAIL reset_data: got %h want 0", rd_data);
      end
   endtask

   task automatic test_single_event();
      pulse(5);
      nvec++;
      if (ts !== 16'd5) begin
         nerr++; $display("FAIL single_ts: got %0d want 5", ts);
      end
      ev[5:4] = 2'd1;
      tick();
      nvec++;
      if (rd_valid !== 1'b0) begin
         nerr++; $display("FAIL single_early: got %b want 0", rd_valid);
      end
      tick();
      nvec++;
      if (rd_valid !== 1'b1) begin
         nerr++; $display("FAIL single_valid: got %b want 1", rd_valid);
      end
      nvec++;
      if (rd_data !== {16'd5, 2'd2, 2'd1}) begin
         nerr++;
         $display("FAIL single_rec: got %h want %h", rd_data,
                  {16'd5, 2'd2, 2'd1});
      end
      repeat (9) tick();
      nvec++;
      if (fcnt !== 5'd1) begin
         nerr++; $display("FAIL single_held: got %0d want 1", fcnt);
      end
      ev = '0;
      rd_ready = 1'b1;
      tick();
      rd_ready = 1'b0;
      nvec++;
      if (fcnt !== 5'd0) begin
         nerr++; $display("FAIL single_pop: got %0d want 0", fcnt);
      end
   endtask

   task automatic test_disable();
      en = 1'b0;
      strobe = 1'b1;
      ev[1:0] = 2'd1;
      tick();
      strobe = 1'b0;
      tick();
      tick();
      nvec++;
      if (ts !== 16'(exp_ts)) begin
         nerr++; $display("FAIL disable_ts: got %0d want %0d", ts, exp_ts);
      end
      nvec++;
      if (rd_valid !== 1'b0) begin
         nerr++; $display("FAIL disable_cap: got %b want 0", rd_valid);
      end
      ev = '0;
      tick();
      en = 1'b1;
   endtask

   task automatic test_simultaneous();
      logic [19:0] exp;
      do_reset();
      pulse(3);
      ev = 8'hAA;
      rd_ready = 1'b1;
      tick();
      tick();
      for (int c = 0; c < 4; c++) begin
         exp = {16'(exp_ts), 2'(c), 2'd2};
         nvec++;
         if (rd_data !== exp || rd_valid !== 1'b1) begin
            nerr++;
            $display("FAIL burst_ch%0d: got %h v=%b want %h", c,
                     rd_data, rd_valid, exp);
         end
         tick();
      end
      nvec++;
      if (rd_valid !== 1'b0) begin
         nerr++; $display("FAIL burst_empty: got %b want 0", rd_valid);
      end
      ev = '0;
      tick();
      ev = 8'h55;
      tick();
      tick();
      exp = {16'(exp_ts), 2'd0, 2'd1};
      nvec++;
      if (rd_data !== exp) begin
         nerr++; $display("FAIL burst2_first: got %h want %h", rd_data, exp);
      end
      ev = '0;
      repeat (5) tick();
      rd_ready = 1'b0;
   endtask

   task automatic test_back_to_back();
      logic [19:0] expq[$];
      logic [1:0]  code;
      int w;
      do_reset();
      for (int r = 0; r < 5; r++) begin
         code = 2'(r % 3 + 1);
         for (int k = 0; k < 4; k++) begin
            ev[2*k +: 2] = code;
            expq.push_back({16'(exp_ts), 2'(k), code});
         end
         strobe = 1'b1;
         tick();
         strobe = 1'b0;
         exp_ts++;
         ev = '0;
         repeat (4) tick();
      end
      nvec++;
      if (fcnt !== 5'd16) begin
         nerr++; $display("FAIL bp_full: got %0d want 16", fcnt);
      end
      nvec++;
      if (ovf !== 16'd0) begin
         nerr++; $display("FAIL bp_ovf: got %0d want 0", ovf);
      end
      rd_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         w = 0;
         while (!rd_valid && w < 5) begin
            tick();
            w++;
         end
         nvec++;
         if (!rd_valid || rd_data !== expq[i]) begin
            nerr++;
            $display("FAIL bp_rec%0d: got %h v=%b want %h", i, rd_data,
                     rd_valid, expq[i]);
         end
         tick();
      end
      repeat (3) tick();
      rd_ready = 1'b0;
      nvec++;
      if (fcnt !== 5'd0) begin
         nerr++; $display("FAIL bp_drained: got %0d want 0", fcnt);
      end
   endtask

   task automatic test_drop();
      logic [19:0] exp;
      int w;
      do_reset();
      for (int r = 0; r < 4; r++) begin
         ev = 8'h55;
         tick();
         ev = '0;
         repeat (4) tick();
      end
      nvec++;
      if (fcnt !== 5'd16) begin
         nerr++; $display("FAIL drop_full: got %0d want 16", fcnt);
      end
      ev[3:2] = 2'd1; tick();
      ev[3:2] = 2'd0; tick();
      ev[3:2] = 2'd2; tick();
      ev[3:2] = 2'd0; tick();
      ev[3:2] = 2'd1; tick();
      ev[3:2] = 2'd0; tick();
      nvec++;
      if (ovf !== 16'd2) begin
         nerr++; $display("FAIL drop_count: got %0d want 2", ovf);
      end
      ev[3:2] = 2'd2;
      clr = 1'b1;
      tick();
      clr = 1'b0;
      ev = '0;
      nvec++;
      if (ovf !== 16'd0) begin
         nerr++; $display("FAIL drop_clrwin: got %0d want 0", ovf);
      end
      tick();
      ev[3:2] = 2'd1; tick();
      ev = '0; tick();
      nvec++;
      if (ovf !== 16'd1) begin
         nerr++; $display("FAIL drop_again: got %0d want 1", ovf);
      end
      clr = 1'b1;
      tick();
      clr = 1'b0;
      nvec++;
      if (ovf !== 16'd0) begin
         nerr++; $display("FAIL drop_clr: got %0d want 0", ovf);
      end
      rd_ready = 1'b1;
      for (int i = 0; i < 17; i++) begin
         exp = (i < 16) ? {16'd0, 2'(i % 4), 2'd1} : {16'd0, 2'd1, 2'd1};
         w = 0;
         while (!rd_valid && w < 5) begin
            tick();
            w++;
         end
         nvec++;
         if (!rd_valid || rd_data !== exp) begin
            nerr++;
            $display("FAIL drop_rec%0d: got %h v=%b want %h", i, rd_data,
                     rd_valid, exp);
         end
         tick();
      end
      tick();
      rd_ready = 1'b0;
      nvec++;
      if (rd_valid !== 1'b0) begin
         nerr++; $display("FAIL drop_extra: got %b want 0", rd_valid);
      end
   endtask

   task automatic test_wrap();
      do_reset();
      pulse(17);
      nvec++;
      if (ts_w !== 4'd1) begin
         nerr++; $display("FAIL wrap_ts: got %0d want 1", ts_w);
      end
      nvec++;
      if (ts !== 16'd17) begin
         nerr++; $display("FAIL wide_ts: got %0d want 17", ts);
      end
      ev_w[1:0] = 2'd1;
      tick();
      tick();
      nvec++;
      if (vld_w !== 1'b1 || dat_w !== {4'd1, 2'd0, 2'd1}) begin
         nerr++;
         $display("FAIL wrap_rec1: got %h v=%b want %h", dat_w, vld_w,
                  {4'd1, 2'd0, 2'd1});
      end
      rdy_w = 1'b1;
      tick();
      rdy_w = 1'b0;
      ev_w[1:0] = 2'd3;
      tick();
      tick();
      nvec++;
      if (cnt_w !== 5'd1 || dat_w !== {4'd1, 2'd0, 2'd3}) begin
         nerr++;
         $display("FAIL code_change: got %h n=%0d want %h", dat_w, cnt_w,
                  {4'd1, 2'd0, 2'd3});
      end
      ev_w = '0;
      rdy_w = 1'b1;
      tick();
      tick();
      rdy_w = 1'b0;
   endtask

   task automatic test_reset_mid();
      do_reset();
      pulse(2);
      ev = 8'hFF;
      tick();
      ev = '0;
      repeat (4) tick();
      ev = 8'h3F;
      tick();
      ev = '0;
      repeat (3) tick();
      ev = 8'h15;
      tick();
      nvec++;
      if (fcnt !== 5'd7) begin
         nerr++; $display("FAIL mid_count: got %0d want 7", fcnt);
      end
      #2;
      rst_n = 1'b0;
      ev = '0;
      #1;
      nvec++;
      if (rd_valid !== 1'b0 || fcnt !== 5'd0 || ts !== 16'd0 ||
          rd_data !== 20'd0 || ovf !== 16'd0) begin
         nerr++;
         $display("FAIL mid_async: got v=%b n=%0d ts=%0d d=%h o=%0d want 0",
                  rd_valid, fcnt, ts, rd_data, ovf);
      end
      tick();
      rst_n = 1'b1;
      exp_ts = 0;
      ev = 8'hFF;
      tick();
      tick();
      nvec++;
      if (rd_data !== {16'd0, 2'd0, 2'd3}) begin
         nerr++;
         $display("FAIL mid_first: got %h want %h", rd_data,
                  {16'd0, 2'd0, 2'd3});
      end
      ev = '0;
   endtask

   initial begin
      test_reset();
      test_single_event();
      test_disable();
      test_simultaneous();
      test_back_to_back();
      test_drop();
      test_wrap();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

endmodule
